mvau_wmem_sched: RTL
====================

// Module: mvau_wmem_sched
// PURPOSE
//  Sequencer for one PE-lane MVAU weight memory (SIMD*TW words, depth SF*NF, 1-cycle registered read, no enable).
//  Consumes the activation stream, schedules weight and input-buffer addresses over synapse fold (SF) x neuron
//  fold (NF), replays buffered activations for NF>0, and emits a valid/flag stream aligned with weight data.
//  Sits between the input AXIS slave, the weight memory / input buffer, and the MAC/accumulator stage.
// PARAMETERS
//  SIMD          2   input lanes per PE
//  PE            2   processing elements
//  MW            4   matrix width (input channels * KDim^2); MW % SIMD == 0
//  MH            4   matrix height (output channels); MH % PE == 0
//  SF            MW/SIMD  synapse fold (localparam)
//  NF            MH/PE    neuron fold (localparam)
//  WMEM_DEPTH    SF*NF    weight memory depth (localparam)
//  WMEM_ADDR_BW  $clog2(WMEM_DEPTH) (min 1)
//  IBUF_ADDR_BW  $clog2(SF) (min 1)
// PORTS
//  aclk          in   1             clock, all logic on rising edge
//  aresetn       in   1             asynchronous active-low reset
//  in_v          in   1             activation beat valid (AXIS tvalid)
//  in_rdy        out  1             activation beat accepted (AXIS tready)
//  out_rdy       in   1             downstream MAC stage ready
//  wmem_addr     out  WMEM_ADDR_BW  weight memory read address (combinational)
//  ibuf_we       out  1             write stream beat into input buffer
//  ibuf_addr     out  IBUF_ADDR_BW  input buffer write/read address (combinational)
//  out_v         out  1             weight/activation data valid at memory outputs this cycle
//  out_src_strm  out  1             1: activation from stream register, 0: from input buffer
//  out_sf_first  out  1             beat is sf==0 (accumulator clear)
//  out_sf_last   out  1             beat is sf==SF-1 (accumulator emit)
//  busy          out  1             matrix-vector operation in progress
// BEHAVIOUR
//  - Reset (async, aresetn=0): state S_FIRST, sf=nf=0, issue counter=0, held addr=0; out_v, out_* flags,
//    ibuf_we, busy = 0. in_rdy = 0 while aresetn=0. Reset mid-operation discards the partial vector.
//  - States: S_FIRST (nf==0: consume stream, write ibuf[sf]); S_REPLAY (nf>0: read ibuf[sf], no stream).
//  - Advance go: S_FIRST: in_v & (~out_v | out_rdy); S_REPLAY: (~out_v | out_rdy). in_rdy = S_FIRST &
//    (~out_v | out_rdy); in_rdy never depends on in_v. ibuf_we = go & S_FIRST.
//  - Issue address: cnt = nf*SF + sf, kept as linear counter 0..WMEM_DEPTH-1, wraps to 0.
//    wmem_addr = go ? cnt : addr_q; ibuf_addr = go ? sf : sf_q (addr_q/sf_q = last issued, updated on go).
//    Holds memory output register stable during stall despite the memory having no read enable.
//  - Latency: one cycle. On edge with go: out_v<=1, flags<=flags of issued beat. Edge with out_rdy & ~go:
//    out_v<=0. Otherwise out_v and flags hold.
//  - Counters on go: sf==SF-1 -> sf=0 and nf++ (nf==NF-1 -> nf=0); else sf++.
//  - Transitions on go: S_FIRST->S_REPLAY when sf==SF-1 and NF>1; S_REPLAY->S_FIRST when sf==SF-1 and
//    nf==NF-1. NF==1: remain in S_FIRST. SF==1: sf stays 0, first and last both set every beat.
//  - busy = (cnt != 0) | out_v.
//  - Back-to-back vectors: last beat of vector k and first beat of k+1 on consecutive cycles, no bubble.
//  - Full throughput: one beat per cycle when in_v (S_FIRST) and out_rdy held high.
// STRUCTURE
//  - mvau_pkg: state enum type (S_FIRST, S_REPLAY), helper function clog2_min1.
//  - Sub-module mvau_fold_cnt: nested sf/nf counter with enable, wrap flags, linear index output.
//  - Top: state register, go/in_rdy logic, address hold mux, output valid/flag register.
// TESTING
//  - SF=2,NF=2: reset, in_v=1, out_rdy=1 -> wmem_addr 0,1,2,3,0; in_rdy 1,1,0,0,1; out_v from cycle 1.
//  - Same, out_rdy=0 for 3 cycles after beat 1 -> wmem_addr/ibuf_addr held at 1, out_v=1 held, no skips.
//  - in_v deasserted in S_FIRST at sf=1 -> in_rdy stays 1, no ibuf_we, counters frozen until in_v=1.
//  - Flags: out_sf_first on addr 0,2; out_sf_last on addr 1,3; out_src_strm=1 only for addr 0,1.
//  - NF=1,SF=1 -> every beat first&last, state never leaves S_FIRST, in_rdy tracks out_rdy.
//  - aresetn pulsed low at addr 2 under stall -> out_v=0 async, restart at wmem_addr 0 in S_FIRST.

Source files
------------

// File: rtl/mvau_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mvau_pkg
//  Description : Shared types and helpers for the MVAU weight-memory
//                sequencer: scheduler state encoding and a clog2 that never
//                returns less than one bit.
//  Revision    : 1.0 - initial release
// ============================================================================
package mvau_pkg;

    // S_FIRST  : neuron fold 0, activations come from the stream and are
    //            captured into the input buffer.
    // S_REPLAY : neuron folds 1..NF-1, activations are replayed from the buffer.
    typedef enum logic [0:0] {
        S_FIRST  = 1'b0,
        S_REPLAY = 1'b1
    } state_t;

    // Address width for a memory of n entries; a single-entry memory still
    // gets a one-bit address so port widths never collapse to zero.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mvau_fold_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : mvau_fold_cnt
//  Description : Nested synapse-fold / neuron-fold counter. sf runs fastest,
//                nf advances when sf wraps. A linear index nf*SF+sf is kept
//                as its own counter so no multiplier is needed.
//  Revision    : 1.0 - initial release
// ============================================================================
module mvau_fold_cnt
    import mvau_pkg::*;
#(
    parameter  int SF     = 2,
    parameter  int NF     = 2,
    localparam int SF_BW  = clog2_min1(SF),
    localparam int NF_BW  = clog2_min1(NF),
    localparam int IDX_BW = clog2_min1(SF * NF)
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              i_en,
    output logic [SF_BW-1:0]  o_sf,
    output logic [IDX_BW-1:0] o_idx,
    output logic              o_sf_last,
    output logic              o_nf_last
);

    localparam logic [SF_BW-1:0] c_SF_LAST = SF_BW'(SF - 1);
    localparam logic [NF_BW-1:0] c_NF_LAST = NF_BW'(NF - 1);

    logic [SF_BW-1:0]  r_sf;
    logic [NF_BW-1:0]  r_nf;
    logic [IDX_BW-1:0] r_idx;
    logic              w_sf_last;
    logic              w_nf_last;

    assign w_sf_last = (r_sf == c_SF_LAST);
    assign w_nf_last = (r_nf == c_NF_LAST);

    // Advance sf, carry into nf, and step the linear index; all wrap together
    // at the end of the full SF x NF schedule.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_sf  <= '0;
            r_nf  <= '0;
            r_idx <= '0;
        end else if (i_en) begin
            if (w_sf_last) begin
                r_sf <= '0;
                r_nf <= w_nf_last ? '0 : r_nf + NF_BW'(1);
            end else begin
                r_sf <= r_sf + SF_BW'(1);
            end
            r_idx <= (w_sf_last && w_nf_last) ? '0 : r_idx + IDX_BW'(1);
        end
    end

    assign o_sf      = r_sf;
    assign o_idx     = r_idx;
    assign o_sf_last = w_sf_last;
    assign o_nf_last = w_nf_last;

endmodule
`default_nettype wire

// File: rtl/mvau_wmem_sched.sv
`default_nettype none
// ============================================================================
//  Module      : mvau_wmem_sched
//  Description : Address/flag sequencer for one PE-lane MVAU weight memory.
//                Accepts activation beats during neuron fold 0, buffers them,
//                replays them for the remaining neuron folds, and produces a
//                valid/flag stream aligned with the 1-cycle memory read data.
//  Revision    : 1.0 - initial release
// ============================================================================
module mvau_wmem_sched
    import mvau_pkg::*;
#(
    parameter  int SIMD         = 2,
    parameter  int PE           = 2,
    parameter  int MW           = 4,
    parameter  int MH           = 4,
    localparam int SF           = MW / SIMD,
    localparam int NF           = MH / PE,
    localparam int WMEM_DEPTH   = SF * NF,
    localparam int WMEM_ADDR_BW = clog2_min1(WMEM_DEPTH),
    localparam int IBUF_ADDR_BW = clog2_min1(SF)
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    in_v,
    output logic                    in_rdy,
    input  logic                    out_rdy,
    output logic [WMEM_ADDR_BW-1:0] wmem_addr,
    output logic                    ibuf_we,
    output logic [IBUF_ADDR_BW-1:0] ibuf_addr,
    output logic                    out_v,
    output logic                    out_src_strm,
    output logic                    out_sf_first,
    output logic                    out_sf_last,
    output logic                    busy
);

    localparam logic c_MULTI_NF = (NF > 1);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    w_go;
    logic                    w_in_rdy;
    logic                    w_ibuf_we;
    logic                    w_slot_free;

    logic [IBUF_ADDR_BW-1:0] w_sf;
    logic [WMEM_ADDR_BW-1:0] w_cnt;
    logic                    w_sf_last;
    logic                    w_nf_last;

    logic [WMEM_ADDR_BW-1:0] r_addr_q;
    logic [IBUF_ADDR_BW-1:0] r_sf_q;
    logic                    r_out_v;
    logic                    r_src_strm;
    logic                    r_sf_first;
    logic                    r_sf_last;

    mvau_fold_cnt #(
        .SF (SF),
        .NF (NF)
    ) u_fold_cnt (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .i_en      (w_go),
        .o_sf      (w_sf),
        .o_idx     (w_cnt),
        .o_sf_last (w_sf_last),
        .o_nf_last (w_nf_last)
    );

    // The output slot can take a new beat when empty or being drained.
    assign w_slot_free = ~r_out_v | out_rdy;

    // Scheduler state register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= S_FIRST;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Issue decision and state transitions; in_rdy is a function of state and
    // downstream space only, never of in_v. Held low while reset is asserted.
    always_comb begin
        w_state_nxt = r_state;
        w_go        = 1'b0;
        w_in_rdy    = 1'b0;
        w_ibuf_we   = 1'b0;
        case (r_state)
            S_FIRST: begin
                w_in_rdy  = aresetn & w_slot_free;
                w_go      = w_in_rdy & in_v;
                w_ibuf_we = w_go;
                if (w_go && w_sf_last && c_MULTI_NF) begin
                    w_state_nxt = S_REPLAY;
                end
            end
            S_REPLAY: begin
                w_go = aresetn & w_slot_free;
                if (w_go && w_sf_last && w_nf_last) begin
                    w_state_nxt = S_FIRST;
                end
            end
            default: begin
                w_state_nxt = S_FIRST;
            end
        endcase
    end

    // Remember the last issued addresses so a stalled beat keeps re-reading
    // the same words; the memories have no read enable.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_addr_q <= '0;
            r_sf_q   <= '0;
        end else if (w_go) begin
            r_addr_q <= w_cnt;
            r_sf_q   <= w_sf;
        end
    end

    // Valid and flags follow the issued beat by one cycle, matching the
    // registered memory read; they hold while downstream stalls.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_out_v    <= 1'b0;
            r_src_strm <= 1'b0;
            r_sf_first <= 1'b0;
            r_sf_last  <= 1'b0;
        end else if (w_go) begin
            r_out_v    <= 1'b1;
            r_src_strm <= (r_state == S_FIRST);
            r_sf_first <= (w_sf == '0);
            r_sf_last  <= w_sf_last;
        end else if (out_rdy) begin
            r_out_v    <= 1'b0;
        end
    end

    assign in_rdy       = w_in_rdy;
    assign ibuf_we      = w_ibuf_we;
    assign wmem_addr    = w_go ? w_cnt : r_addr_q;
    assign ibuf_addr    = w_go ? w_sf : r_sf_q;
    assign out_v        = r_out_v;
    assign out_src_strm = r_src_strm;
    assign out_sf_first = r_sf_first;
    assign out_sf_last  = r_sf_last;
    assign busy         = (w_cnt != '0) | r_out_v;

endmodule
`default_nettype wire
